// File: rtl/dcache_axi_pkg.sv
// -----------------------------------------------------------------------------
// dcache_axi_pkg
// Shared types and constants for the dcache <-> AXI bridge:
//   DWayBus          - one full cache line (16 x 32-bit words)
//   DCACHE_AXI_ID    - default ARID/AWID
//   LEN_LINE / LEN_SINGLE, SIZE_WORD, BURST_INCR - AXI burst attributes
//   rstate_e / wstate_e - read and write engine state encodings
//   line_align()     - clears the in-line offset of an address
// -----------------------------------------------------------------------------
package dcache_axi_pkg;

    typedef logic [511:0] DWayBus;

    localparam logic [3:0] DCACHE_AXI_ID = 4'd1;

    localparam logic [7:0] LEN_LINE   = 8'd15;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_B    = 2'd3
    } wstate_e;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:6], 6'b0};
    endfunction

endpackage

// File: rtl/dcache_axi_if.sv
// -----------------------------------------------------------------------------
// dcache_axi_if
// AXI4 channel bundle (AR, R, AW, W, B) used by the dcache bridge.
//   master modport : the bridge (drives AR/AW/W valids, R/B readies)
//   slave  modport : the interconnect / memory model
// RRESP/BRESP/RID/BID are not carried; the bridge ignores them.
// -----------------------------------------------------------------------------
interface dcache_axi_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/dcache_line_buf.sv
// -----------------------------------------------------------------------------
// dcache_line_buf
// Refill assembly buffer: WORDS x 32-bit register file with one indexed word
// write port and a flat read of the whole line.
//   clk, rst_n : clock, async active-low reset (clears every word)
//   we         : write enable
//   waddr      : word index to write
//   wdata      : word to write
//   rdata      : whole line, word k at bits 32k+31:32k
// Every word is a plain register so the whole line can be read in parallel.
// -----------------------------------------------------------------------------
module dcache_line_buf #(
    parameter int WORDS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(WORDS)-1:0]   waddr,
    input  logic [31:0]                wdata,
    output logic [WORDS*32-1:0]        rdata
);

    localparam int AW = $clog2(WORDS);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign rdata[gi*32 +: 32] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/dcache_axi.sv
// -----------------------------------------------------------------------------
// dcache_axi
// Bridge between dcache stage 2 and an AXI master port. Runs cached refills
// (16-beat INCR read), dirty-victim writebacks (16-beat INCR write) and
// single-beat uncached reads/writes. Read and write engines are independent,
// so a refill may overlap an outstanding write response.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   ca_rreq_i / ca_wreq_i      one-cycle pulses: cached refill / writeback
//   uc_rreq_i / uc_wreq_i      one-cycle pulses: uncached read / write
//   addr_i                     request address
//   uc_wen_i, uc_wdata_i       uncached write strobes / data
//   wb_line_i                  victim line, sampled with ca_wreq_i
//   rend_o                     pulse: read done, line_rdata_o valid
//   write_ok_o                 pulse: cached writeback done
//   wend_o                     pulse: uncached write done
//   line_rdata_o               assembled read line
//   axi                        AXI master channels (dcache_axi_if.master)
//
// Build option
//   DCACHE_AXI_EARLY_WOK_EN    write_ok_o pulses after the last W beat of a
//                              writeback instead of after B; the write engine
//                              still waits for B before taking a new request.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module dcache_axi
    import dcache_axi_pkg::*;
#(
    parameter int         LINE_WORDS = 16,
    parameter logic [3:0] AXI_ID     = DCACHE_AXI_ID
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       ca_rreq_i,
    input  logic                       ca_wreq_i,
    input  logic                       uc_rreq_i,
    input  logic                       uc_wreq_i,
    input  logic [31:0]                addr_i,
    input  logic [3:0]                 uc_wen_i,
    input  logic [31:0]                uc_wdata_i,
    input  logic [LINE_WORDS*32-1:0]   wb_line_i,

    output logic                       rend_o,
    output logic                       write_ok_o,
    output logic                       wend_o,
    output logic [LINE_WORDS*32-1:0]   line_rdata_o,

    dcache_axi_if.master               axi
);

    localparam int CNT_W = $clog2(LINE_WORDS);

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rstate_e            r_state_reg, r_state_next;
    logic [CNT_W-1:0]   r_cnt_reg;
    logic [3:0]         arid_reg;
    logic [31:0]        araddr_reg;
    logic [7:0]         arlen_reg;
    logic [2:0]         arsize_reg;
    logic [1:0]         arburst_reg;
    logic               arvalid_reg;
    logic               rready_reg;
    logic               rend_reg;
    logic               rd_req;
    logic               r_hs;

    assign rd_req = ca_rreq_i | uc_rreq_i;
    assign r_hs   = axi.rvalid & rready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (rd_req)               r_state_next = R_AR;
            R_AR:    if (axi.arready)          r_state_next = R_DATA;
            R_DATA:  if (r_hs && axi.rlast)    r_state_next = R_IDLE;
            default:                           r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arid_reg    <= '0;
            araddr_reg  <= '0;
            arlen_reg   <= '0;
            arsize_reg  <= '0;
            arburst_reg <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            rend_reg    <= 1'b0;
            r_cnt_reg   <= '0;
        end else begin
            rend_reg <= 1'b0;
            case (r_state_reg)
                R_IDLE: begin
                    if (rd_req) begin
                        arid_reg    <= AXI_ID;
                        arsize_reg  <= SIZE_WORD;
                        arburst_reg <= BURST_INCR;
                        arvalid_reg <= 1'b1;
                        if (ca_rreq_i) begin
                            araddr_reg <= line_align(addr_i);
                            arlen_reg  <= LEN_LINE;
                            r_cnt_reg  <= '0;
                        end else begin
                            // Uncached data lands in the word its address
                            // selects, so stage 2 can pick it from the line.
                            araddr_reg <= addr_i;
                            arlen_reg  <= LEN_SINGLE;
                            r_cnt_reg  <= addr_i[CNT_W+1:2];
                        end
                    end
                end
                R_AR: begin
                    if (axi.arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        r_cnt_reg <= r_cnt_reg + 1'b1;
                        if (axi.rlast) begin
                            rready_reg <= 1'b0;
                            rend_reg   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    dcache_line_buf #(
        .WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (r_hs),
        .waddr (r_cnt_reg),
        .wdata (axi.rdata),
        .rdata (line_rdata_o)
    );

    assign axi.arid    = arid_reg;
    assign axi.araddr  = araddr_reg;
    assign axi.arlen   = arlen_reg;
    assign axi.arsize  = arsize_reg;
    assign axi.arburst = arburst_reg;
    assign axi.arvalid = arvalid_reg;
    assign axi.rready  = rready_reg;
    assign rend_o      = rend_reg;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wstate_e                  w_state_reg, w_state_next;
    logic [CNT_W-1:0]         w_cnt_reg;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic                     w_cached_reg;
    logic [LINE_WORDS*32-1:0] wb_line_reg;
    logic [31:0]              uc_wdata_reg;
    logic [3:0]               uc_wen_reg;
    logic [3:0]               awid_reg;
    logic [31:0]              awaddr_reg;
    logic [7:0]               awlen_reg;
    logic [2:0]               awsize_reg;
    logic [1:0]               awburst_reg;
    logic                     awvalid_reg;
    logic [31:0]              wdata_reg;
    logic [3:0]               wstrb_reg;
    logic                     wlast_reg;
    logic                     wvalid_reg;
    logic                     bready_reg;
    logic                     write_ok_reg;
    logic                     wend_reg;
    logic                     w_hs;

    assign w_hs      = wvalid_reg & axi.wready;
    assign w_cnt_inc = w_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (ca_wreq_i || uc_wreq_i) w_state_next = W_AW;
            W_AW:    if (axi.awready)            w_state_next = W_DATA;
            W_DATA:  if (w_hs && wlast_reg)      w_state_next = W_B;
            W_B:     if (axi.bvalid)             w_state_next = W_IDLE;
            default:                             w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_cnt_reg    <= '0;
            w_cached_reg <= 1'b0;
            wb_line_reg  <= '0;
            uc_wdata_reg <= '0;
            uc_wen_reg   <= '0;
            awid_reg     <= '0;
            awaddr_reg   <= '0;
            awlen_reg    <= '0;
            awsize_reg   <= '0;
            awburst_reg  <= '0;
            awvalid_reg  <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            wlast_reg    <= 1'b0;
            wvalid_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            write_ok_reg <= 1'b0;
            wend_reg     <= 1'b0;
        end else begin
            write_ok_reg <= 1'b0;
            wend_reg     <= 1'b0;
            case (w_state_reg)
                W_IDLE: begin
                    if (ca_wreq_i || uc_wreq_i) begin
                        awid_reg    <= AXI_ID;
                        awsize_reg  <= SIZE_WORD;
                        awburst_reg <= BURST_INCR;
                        awvalid_reg <= 1'b1;
                        w_cnt_reg   <= '0;
                        w_cached_reg <= ca_wreq_i;
                        if (ca_wreq_i) begin
                            wb_line_reg <= wb_line_i;
                            awaddr_reg  <= line_align(addr_i);
                            awlen_reg   <= LEN_LINE;
                        end else begin
                            uc_wdata_reg <= uc_wdata_i;
                            uc_wen_reg   <= uc_wen_i;
                            awaddr_reg   <= addr_i;
                            awlen_reg    <= LEN_SINGLE;
                        end
                    end
                end
                W_AW: begin
                    // First W beat is staged here so wvalid only rises
                    // after the address has been accepted.
                    if (axi.awready) begin
                        awvalid_reg <= 1'b0;
                        wvalid_reg  <= 1'b1;
                        wdata_reg   <= w_cached_reg ? wb_line_reg[31:0] : uc_wdata_reg;
                        wstrb_reg   <= w_cached_reg ? 4'hF : uc_wen_reg;
                        wlast_reg   <= ~w_cached_reg;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_cnt_reg <= w_cnt_inc;
                        if (wlast_reg) begin
                            wvalid_reg <= 1'b0;
                            wlast_reg  <= 1'b0;
                            bready_reg <= 1'b1;
`ifdef DCACHE_AXI_EARLY_WOK_EN
                            write_ok_reg <= w_cached_reg;
`endif
                        end else begin
                            wdata_reg <= wb_line_reg[{w_cnt_inc, 5'b0} +: 32];
                            wlast_reg <= (w_cnt_inc == CNT_W'(LINE_WORDS - 1));
                        end
                    end
                end
                W_B: begin
                    if (axi.bvalid) begin
                        bready_reg <= 1'b0;
                        wend_reg   <= ~w_cached_reg;
`ifdef DCACHE_AXI_EARLY_WOK_EN
`else
                        write_ok_reg <= w_cached_reg;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi.awid    = awid_reg;
    assign axi.awaddr  = awaddr_reg;
    assign axi.awlen   = awlen_reg;
    assign axi.awsize  = awsize_reg;
    assign axi.awburst = awburst_reg;
    assign axi.awvalid = awvalid_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wlast   = wlast_reg;
    assign axi.wvalid  = wvalid_reg;
    assign axi.bready  = bready_reg;
    assign write_ok_o  = write_ok_reg;
    assign wend_o      = wend_reg;

endmodule

// File: tb/tb_dcache_axi.sv
// -----------------------------------------------------------------------------
// tb_dcache_axi
// Scoreboard bench for dcache_axi. Stimulus pushes expected AR/AW/W/rend/
// write_ok/wend events into queues; a negedge monitor pops and compares them
// as the DUT presents them. Small AXI slave processes supply R data, W ready
// stalls and B responses.
// -----------------------------------------------------------------------------
`define CHK(n, a, e) chk(n, 512'(a), 512'(e))

module tb_dcache_axi;

    typedef struct { logic [31:0] addr; logic [7:0] len; int cyc; } addr_exp_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_exp_t;
    typedef struct { logic [511:0] line; int cyc; } rd_exp_t;

    logic         clk;
    logic         rst_n;
    logic         ca_rreq, ca_wreq, uc_rreq, uc_wreq;
    logic [31:0]  addr;
    logic [3:0]   uc_wen;
    logic [31:0]  uc_wdata;
    logic [511:0] wb_line;
    logic         rend, write_ok, wend;
    logic [511:0] line_rdata;

    dcache_axi_if bus();

    dcache_axi #(
        .LINE_WORDS (16),
        .AXI_ID     (4'd1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ca_rreq_i    (ca_rreq),
        .ca_wreq_i    (ca_wreq),
        .uc_rreq_i    (uc_rreq),
        .uc_wreq_i    (uc_wreq),
        .addr_i       (addr),
        .uc_wen_i     (uc_wen),
        .uc_wdata_i   (uc_wdata),
        .wb_line_i    (wb_line),
        .rend_o       (rend),
        .write_ok_o   (write_ok),
        .wend_o       (wend),
        .line_rdata_o (line_rdata),
        .axi          (bus)
    );

    addr_exp_t ar_q[$], aw_q[$];
    w_exp_t    w_q[$];
    rd_exp_t   rd_q[$];
    int        wok_q[$], wend_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // slave controls (written only by the main stimulus process)
    logic [31:0] rd_seed = 32'h0;
    logic        rgap = 1'b0;
    int          b_delay = 0;
    int          w_stall_beat = -1;
    int          w_stall_cycles = 0;
    logic        abort = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event at cycle %0d, expected none", name, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        addr_exp_t ae;
        w_exp_t    we;
        rd_exp_t   re;
        int        c;
        if (rst_n) begin
            if (bus.arvalid && bus.arready) begin
                $display("[%0d] AR addr=%h len=%0d", cyc, bus.araddr, bus.arlen);
                if (ar_q.size() == 0) unexpected("ar");
                else begin
                    ae = ar_q.pop_front();
                    `CHK("ar_addr", bus.araddr, ae.addr);
                    `CHK("ar_len", bus.arlen, ae.len);
                    `CHK("ar_size", bus.arsize, 3'd2);
                    `CHK("ar_burst", bus.arburst, 2'b01);
                    `CHK("ar_id", bus.arid, 4'd1);
                    if (ae.cyc >= 0) `CHK("ar_cycle", cyc, ae.cyc);
                end
            end
            if (bus.awvalid && bus.awready) begin
                $display("[%0d] AW addr=%h len=%0d", cyc, bus.awaddr, bus.awlen);
                if (aw_q.size() == 0) unexpected("aw");
                else begin
                    ae = aw_q.pop_front();
                    `CHK("aw_addr", bus.awaddr, ae.addr);
                    `CHK("aw_len", bus.awlen, ae.len);
                    `CHK("aw_size", bus.awsize, 3'd2);
                    `CHK("aw_burst", bus.awburst, 2'b01);
                    `CHK("aw_id", bus.awid, 4'd1);
                    if (ae.cyc >= 0) `CHK("aw_cycle", cyc, ae.cyc);
                end
            end
            if (bus.wvalid && bus.wready) begin
                $display("[%0d] W data=%h strb=%h last=%0b", cyc, bus.wdata, bus.wstrb, bus.wlast);
                if (w_q.size() == 0) unexpected("w_beat");
                else begin
                    we = w_q.pop_front();
                    `CHK("w_data", bus.wdata, we.data);
                    `CHK("w_strb", bus.wstrb, we.strb);
                    `CHK("w_last", bus.wlast, we.last);
                end
            end
            if (rend) begin
                $display("[%0d] REND", cyc);
                if (rd_q.size() == 0) unexpected("rend");
                else begin
                    re = rd_q.pop_front();
                    `CHK("rend_line", line_rdata, re.line);
                    if (re.cyc >= 0) `CHK("rend_cycle", cyc, re.cyc);
                end
            end
            if (write_ok) begin
                $display("[%0d] WRITE_OK", cyc);
                if (wok_q.size() == 0) unexpected("write_ok");
                else begin
                    c = wok_q.pop_front();
                    `CHK("write_ok_cycle", cyc, c);
                end
            end
            if (wend) begin
                $display("[%0d] WEND", cyc);
                if (wend_q.size() == 0) unexpected("wend");
                else begin
                    c = wend_q.pop_front();
                    `CHK("wend_cycle", cyc, c);
                end
            end
        end
    end

    // ---------------- AXI slave: R channel ----------------
    initial begin : r_slave
        logic [31:0] base;
        int          len;
        int          budget;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.arvalid && bus.arready) begin
                base = bus.araddr;
                len  = int'(bus.arlen);
                @(posedge clk); #1;
                for (int k = 0; k <= len; k++) begin
                    if (abort) break;
                    if (k > 0 && rgap) begin
                        bus.rvalid = 1'b0;
                        @(posedge clk); #1;
                    end
                    bus.rvalid = 1'b1;
                    bus.rdata  = rd_seed + 32'((base[5:2] + 4'(k)));
                    bus.rlast  = (k == len);
                    budget = 0;
                    @(negedge clk);
                    while (!bus.rready && !abort && budget < 50) begin
                        budget++;
                        @(negedge clk);
                    end
                    if (budget >= 50) unexpected("r_beat_timeout");
                    @(posedge clk); #1;
                end
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
            end
        end
    end

    // ---------------- AXI slave: W ready with optional stall ----------------
    initial begin : w_slave
        int  seen;
        int  stalled;
        logic hs, lastb;
        seen = 0;
        stalled = 0;
        bus.wready = 1'b1;
        forever begin
            @(negedge clk);
            hs    = bus.wvalid && bus.wready;
            lastb = bus.wlast;
            @(posedge clk); #1;
            if (hs) begin
                stalled = 0;
                seen = lastb ? 0 : seen + 1;
            end
            if (seen == w_stall_beat && stalled < w_stall_cycles) begin
                bus.wready = 1'b0;
                stalled++;
            end else begin
                bus.wready = 1'b1;
            end
        end
    end

    // ---------------- AXI slave: B channel ----------------
    initial begin : b_slave
        int budget;
        bus.bvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wvalid && bus.wready && bus.wlast) begin
                @(posedge clk); #1;
                for (int i = 0; i < b_delay && !abort; i++) begin
                    @(posedge clk); #1;
                end
                if (!abort) begin
                    bus.bvalid = 1'b1;
                    budget = 0;
                    @(negedge clk);
                    while (!bus.bready && !abort && budget < 50) begin
                        budget++;
                        @(negedge clk);
                    end
                    if (budget >= 50) unexpected("b_timeout");
                    @(posedge clk); #1;
                    bus.bvalid = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int kind, input logic [31:0] a, output int t);
        @(posedge clk); #1;
        t    = cyc;
        addr = a;
        case (kind)
            0: ca_rreq = 1'b1;
            1: uc_rreq = 1'b1;
            2: ca_wreq = 1'b1;
            default: uc_wreq = 1'b1;
        endcase
        @(posedge clk); #1;
        ca_rreq = 1'b0;
        uc_rreq = 1'b0;
        ca_wreq = 1'b0;
        uc_wreq = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (ar_q.size() + aw_q.size() + w_q.size() + rd_q.size()
                + wok_q.size() + wend_q.size() == 0) break;
        end
        left = ar_q.size() + aw_q.size() + w_q.size() + rd_q.size()
               + wok_q.size() + wend_q.size();
        `CHK("drain_pending", left, 0);
        ar_q.delete(); aw_q.delete(); w_q.delete(); rd_q.delete();
        wok_q.delete(); wend_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- main stimulus ----------------
    initial begin : stim
        int           t, t2;
        logic [511:0] model_line;
        logic [511:0] line;

        rst_n    = 1'b0;
        ca_rreq  = 1'b0;
        ca_wreq  = 1'b0;
        uc_rreq  = 1'b0;
        uc_wreq  = 1'b0;
        addr     = '0;
        uc_wen   = '0;
        uc_wdata = '0;
        wb_line  = '0;
        bus.arready = 1'b1;
        bus.awready = 1'b1;
        model_line  = '0;

        repeat (3) @(posedge clk);
        #1;
        `CHK("rst_arvalid", bus.arvalid, 1'b0);
        `CHK("rst_awvalid", bus.awvalid, 1'b0);
        `CHK("rst_wvalid", bus.wvalid, 1'b0);
        `CHK("rst_wlast", bus.wlast, 1'b0);
        `CHK("rst_rready", bus.rready, 1'b0);
        `CHK("rst_bready", bus.bready, 1'b0);
        `CHK("rst_araddr", bus.araddr, 32'h0);
        `CHK("rst_awlen", bus.awlen, 8'h0);
        `CHK("rst_pulses", {rend, write_ok, wend}, 3'b000);
        `CHK("rst_line", line_rdata, 512'h0);
        rst_n = 1'b1;

        // 1: zero-wait cached refill
        rd_seed = 32'hA000_0000;
        rgap = 1'b0;
        issue(0, 32'h8000_1234, t);
        for (int k = 0; k < 16; k++) model_line[32*k +: 32] = 32'hA000_0000 + 32'(k);
        ar_q.push_back('{addr: 32'h8000_1200, len: 8'd15, cyc: t + 1});
        rd_q.push_back('{line: model_line, cyc: t + 18});
        wait_drain(60);
        `CHK("t1_word13", line_rdata[13*32 +: 32], 32'hA000_000D);

        // 2: refill with rvalid gaps
        rd_seed = 32'hC000_0000;
        rgap = 1'b1;
        issue(0, 32'h8000_2000, t);
        for (int k = 0; k < 16; k++) model_line[32*k +: 32] = 32'hC000_0000 + 32'(k);
        ar_q.push_back('{addr: 32'h8000_2000, len: 8'd15, cyc: t + 1});
        rd_q.push_back('{line: model_line, cyc: -1});
        wait_drain(80);
        rgap = 1'b0;

        // 3: writeback, word k = k, wready low 3 cycles at beat 5
        for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'(k);
        wb_line = line;
        w_stall_beat = 5;
        w_stall_cycles = 3;
        b_delay = 0;
        issue(2, 32'h8000_4A40, t);
        wb_line = '0;
        aw_q.push_back('{addr: 32'h8000_4A40, len: 8'd15, cyc: t + 1});
        for (int k = 0; k < 16; k++) w_q.push_back('{data: 32'(k), strb: 4'hF, last: (k == 15)});
`ifdef DCACHE_AXI_EARLY_WOK_EN
        wok_q.push_back(t + 21);
`else
        wok_q.push_back(t + 22);
`endif
        wait_drain(60);
        w_stall_beat = -1;

        // 4: uncached read
        rd_seed = 32'h1111_0000;
        issue(1, 32'hBFAF_8008, t);
        model_line[2*32 +: 32] = 32'h1111_0002;
        ar_q.push_back('{addr: 32'hBFAF_8008, len: 8'd0, cyc: t + 1});
        rd_q.push_back('{line: model_line, cyc: t + 3});
        wait_drain(30);
        `CHK("t4_word2", line_rdata[2*32 +: 32], 32'h1111_0002);

        // 6: writeback waiting in W_B, refill overlaps, then reset mid-burst
        for (int k = 0; k < 16; k++) line[32*k +: 32] = 32'h100 + 32'(k);
        wb_line = line;
        b_delay = 40;
        issue(2, 32'h8000_5000, t);
        aw_q.push_back('{addr: 32'h8000_5000, len: 8'd15, cyc: t + 1});
        for (int k = 0; k < 16; k++) w_q.push_back('{data: 32'h100 + 32'(k), strb: 4'hF, last: (k == 15)});
`ifdef DCACHE_AXI_EARLY_WOK_EN
        wok_q.push_back(t + 18);
`endif
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.bready) break;
        end
        `CHK("t6_in_wb", bus.bready, 1'b1);
        rd_seed = 32'hD000_0000;
        issue(0, 32'h8000_6040, t2);
        ar_q.push_back('{addr: 32'h8000_6040, len: 8'd15, cyc: t2 + 1});
        `CHK("t6_arvalid_while_b", bus.arvalid, 1'b1);
        `CHK("t6_bready_while_ar", bus.bready, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        `CHK("t6_rready_mid", bus.rready, 1'b1);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        `CHK("t6_rst_arvalid", bus.arvalid, 1'b0);
        `CHK("t6_rst_rready", bus.rready, 1'b0);
        `CHK("t6_rst_awvalid", bus.awvalid, 1'b0);
        `CHK("t6_rst_wvalid", bus.wvalid, 1'b0);
        `CHK("t6_rst_bready", bus.bready, 1'b0);
        `CHK("t6_rst_pulses", {rend, write_ok, wend}, 3'b000);
        `CHK("t6_rst_line", line_rdata, 512'h0);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b0;
        b_delay = 0;
        wb_line = '0;
        `CHK("t6_drain_after_rst", ar_q.size() + aw_q.size() + w_q.size() + wok_q.size(), 0);
        ar_q.delete(); aw_q.delete(); w_q.delete(); wok_q.delete();
        rst_n = 1'b1;

        // 5: uncached write after reset (write engine must be idle)
        uc_wen = 4'b0011;
        uc_wdata = 32'h1234_5678;
        issue(3, 32'h1FC0_0014, t);
        aw_q.push_back('{addr: 32'h1FC0_0014, len: 8'd0, cyc: t + 1});
        w_q.push_back('{data: 32'h1234_5678, strb: 4'h3, last: 1'b1});
        wend_q.push_back(t + 4);
        wait_drain(30);

        // uncached read after reset (read engine idle, line buffer cleared)
        rd_seed = 32'h2222_0000;
        model_line = '0;
        model_line[1*32 +: 32] = 32'h2222_0001;
        issue(1, 32'hA000_0004, t);
        ar_q.push_back('{addr: 32'hA000_0004, len: 8'd0, cyc: t + 1});
        rd_q.push_back('{line: model_line, cyc: t + 3});
        wait_drain(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
